// File: rtl/stg_pkg.sv
// Shared definitions for the STG playfield: phase and bullet-pattern codes,
// playfield limits and default boss home position.
package stg_pkg;

   typedef enum logic [2:0] {
      PhIdle   = 3'd0,
      PhEnter  = 3'd1,
      PhSweepR = 3'd2,
      PhSweepL = 3'd3,
      PhDead   = 3'd4
   } phase_e;

   typedef enum logic [1:0] {
      PatAimed  = 2'd0,
      PatRing   = 2'd1,
      PatSpiral = 2'd2
   } pattern_e;

   localparam int unsigned MAX_X      = 384;
   localparam int unsigned MAX_Y      = 448;
   localparam int unsigned X_HOME_DEF = 192;
   localparam int unsigned Y_HOME_DEF = 100;

   // Bullet pattern escalates as the boss loses health.
   function automatic pattern_e pattern_from_health(input logic [7:0] health,
                                                    input int unsigned life_init);
      if (32'(health) > life_init / 2) begin
         return PatAimed;
      end else if (32'(health) > life_init / 4) begin
         return PatRing;
      end else begin
         return PatSpiral;
      end
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: tick is high for one clk_in cycle out of every DIV.
module tick_divider #(
   parameter int unsigned DIV = 5000000
) (
   input  logic clk_in,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] Last = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == Last);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/boss_phase_sequencer.sv
// Boss encounter sequencer: entry, left/right sweep and death phases, health
// tracking, and bullet spawn requests over a valid/ready handshake.
module boss_phase_sequencer
   import stg_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 5000000,
   parameter int unsigned X_HOME      = X_HOME_DEF,
   parameter int unsigned Y_HOME      = Y_HOME_DEF,
   parameter int unsigned X_MIN       = 64,
   parameter int unsigned X_MAX       = 320,
   parameter int unsigned LIFE_INIT   = 20,
   parameter int unsigned FIRE_PERIOD = 30
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       start,
   input  logic       hit,
   input  logic       spawn_ready,
   output logic       spawn_valid,
   output logic [1:0] spawn_pattern,
   output logic [9:0] spawn_x,
   output logic [9:0] spawn_y,
   output logic [9:0] boss_x,
   output logic [9:0] boss_y,
   output logic [7:0] health,
   output logic [2:0] phase,
   output logic       active,
   output logic       die,
   output logic       frame_tick
);

   localparam int unsigned FCW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
   localparam logic [FCW-1:0] FireLast = FCW'(FIRE_PERIOD - 1);
   localparam logic [9:0]     XHome    = 10'(X_HOME);
   localparam logic [9:0]     YHome    = 10'(Y_HOME);
   localparam logic [9:0]     XMin     = 10'(X_MIN);
   localparam logic [9:0]     XMax     = 10'(X_MAX);
   localparam logic [7:0]     LifeInit = 8'(LIFE_INIT);

   phase_e         phase_q, phase_d;
   logic [9:0]     boss_x_q, boss_x_d, boss_y_q, boss_y_d;
   logic [7:0]     health_q, health_d;
   logic [FCW-1:0] fire_cnt_q, fire_cnt_d;
   logic           hit_d_q, hit_d_d;
   logic           spawn_valid_q, spawn_valid_d;
   pattern_e       spawn_pattern_q, spawn_pattern_d;
   logic [9:0]     spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
   logic           fire_evt;
   logic           hit_edge;

   tick_divider #(
      .DIV (TICK_DIV)
   ) u_tick_divider (
      .clk_in (clk_in),
      .reset  (reset),
      .tick   (frame_tick)
   );

   assign hit_edge = hit & ~hit_d_q;

   always_comb begin
      phase_d         = phase_q;
      boss_x_d        = boss_x_q;
      boss_y_d        = boss_y_q;
      health_d        = health_q;
      fire_cnt_d      = fire_cnt_q;
      hit_d_d         = hit;
      spawn_valid_d   = spawn_valid_q;
      spawn_pattern_d = spawn_pattern_q;
      spawn_x_d       = spawn_x_q;
      spawn_y_d       = spawn_y_q;
      fire_evt        = 1'b0;

      if (spawn_valid_q && spawn_ready) begin
         spawn_valid_d = 1'b0;
      end

      case (phase_q)
         PhIdle: begin
            if (start) begin
               phase_d    = PhEnter;
               health_d   = LifeInit;
               boss_x_d   = XHome;
               boss_y_d   = '0;
               fire_cnt_d = '0;
            end
         end
         PhEnter: begin
            if (frame_tick) begin
               boss_y_d = boss_y_q + 10'd1;
               if (boss_y_d == YHome) begin
                  phase_d = PhSweepR;
               end
            end
         end
         PhSweepR, PhSweepL: begin
            if (frame_tick) begin
               if (phase_q == PhSweepR) begin
                  boss_x_d = boss_x_q + 10'd1;
                  if (boss_x_d == XMax) begin
                     phase_d = PhSweepL;
                  end
               end else begin
                  boss_x_d = boss_x_q - 10'd1;
                  if (boss_x_d == XMin) begin
                     phase_d = PhSweepR;
                  end
               end
               if (fire_cnt_q == FireLast) begin
                  fire_cnt_d = '0;
                  fire_evt   = 1'b1;
               end else begin
                  fire_cnt_d = fire_cnt_q + FCW'(1);
               end
            end
            // Pending check uses the registered valid, so a transfer edge drops a new event.
            if (fire_evt && !spawn_valid_q) begin
               spawn_valid_d   = 1'b1;
               spawn_x_d       = boss_x_q;
               spawn_y_d       = boss_y_q;
               spawn_pattern_d = pattern_from_health(health_q, LIFE_INIT);
            end
            if (hit_edge && (health_q != 8'd0)) begin
               health_d = health_q - 8'd1;
               if (health_q == 8'd1) begin
                  phase_d       = PhDead;
                  spawn_valid_d = 1'b0;
               end
            end
         end
         PhDead: begin
         end
         default: begin
            phase_d = PhIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         phase_q         <= PhIdle;
         boss_x_q        <= XHome;
         boss_y_q        <= '0;
         health_q        <= LifeInit;
         fire_cnt_q      <= '0;
         hit_d_q         <= 1'b0;
         spawn_valid_q   <= 1'b0;
         spawn_pattern_q <= PatAimed;
         spawn_x_q       <= '0;
         spawn_y_q       <= '0;
      end else begin
         phase_q         <= phase_d;
         boss_x_q        <= boss_x_d;
         boss_y_q        <= boss_y_d;
         health_q        <= health_d;
         fire_cnt_q      <= fire_cnt_d;
         hit_d_q         <= hit_d_d;
         spawn_valid_q   <= spawn_valid_d;
         spawn_pattern_q <= spawn_pattern_d;
         spawn_x_q       <= spawn_x_d;
         spawn_y_q       <= spawn_y_d;
      end
   end

   assign phase         = phase_q;
   assign boss_x        = boss_x_q;
   assign boss_y        = boss_y_q;
   assign health        = health_q;
   assign spawn_valid   = spawn_valid_q;
   assign spawn_pattern = spawn_pattern_q;
   assign spawn_x       = spawn_x_q;
   assign spawn_y       = spawn_y_q;
   assign active        = (phase_q == PhEnter) || (phase_q == PhSweepR) || (phase_q == PhSweepL);
   assign die           = (phase_q == PhDead);

endmodule

// File: tb/tb_boss_phase_sequencer.sv
// Directed bench for boss_phase_sequencer with a short divider and small limits;
// edge numbers in the notes count clk_in posedges since reset release.
module tb_boss_phase_sequencer;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       start;
   logic       hit;
   logic       spawn_ready;
   logic       spawn_valid;
   logic [1:0] spawn_pattern;
   logic [9:0] spawn_x, spawn_y, boss_x, boss_y;
   logic [7:0] health;
   logic [2:0] phase;
   logic       active, die, frame_tick;

   int vectors    = 0;
   int miscompares = 0;

   boss_phase_sequencer #(
      .TICK_DIV    (4),
      .X_HOME      (192),
      .Y_HOME      (4),
      .X_MIN       (188),
      .X_MAX       (196),
      .LIFE_INIT   (8),
      .FIRE_PERIOD (3)
   ) dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .start         (start),
      .hit           (hit),
      .spawn_ready   (spawn_ready),
      .spawn_valid   (spawn_valid),
      .spawn_pattern (spawn_pattern),
      .spawn_x       (spawn_x),
      .spawn_y       (spawn_y),
      .boss_x        (boss_x),
      .boss_y        (boss_y),
      .health        (health),
      .phase         (phase),
      .active        (active),
      .die           (die),
      .frame_tick    (frame_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_phase"}, 32'(phase), 0);
      chk({pfx, "_x"}, 32'(boss_x), 192);
      chk({pfx, "_y"}, 32'(boss_y), 0);
      chk({pfx, "_health"}, 32'(health), 8);
      chk({pfx, "_valid"}, 32'(spawn_valid), 0);
      chk({pfx, "_pat"}, 32'(spawn_pattern), 0);
      chk({pfx, "_sx"}, 32'(spawn_x), 0);
      chk({pfx, "_sy"}, 32'(spawn_y), 0);
      chk({pfx, "_active"}, 32'(active), 0);
      chk({pfx, "_die"}, 32'(die), 0);
      chk({pfx, "_tick"}, 32'(frame_tick), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hit = 1'b0; spawn_ready = 1'b0;
      step(2);
      chk_reset_state("rst");
      reset = 1'b0;

      // Divider: tick visible after the 3rd edge, consumed on the 4th.
      step(1); chk("tick_e1", 32'(frame_tick), 0);
      step(1); chk("tick_e2", 32'(frame_tick), 0);
      step(1); chk("tick_e3", 32'(frame_tick), 1);
      chk("idle_phase", 32'(phase), 0);
      start = 1'b1;
      step(1);                              // edge 4
      start = 1'b0;
      chk("enter_phase", 32'(phase), 1);
      chk("enter_active", 32'(active), 1);
      chk("enter_y0", 32'(boss_y), 0);
      chk("enter_tick_low", 32'(frame_tick), 0);

      step(4); chk("enter_y1", 32'(boss_y), 1);      // edge 8
      hit = 1'b1;
      step(1); chk("enter_hit_ignored", 32'(health), 8);
      hit = 1'b0;
      step(2); chk("enter_y_hold", 32'(boss_y), 1);  // edge 11
      step(1); chk("enter_y2", 32'(boss_y), 2);      // edge 12
      step(8);                                        // edge 20
      chk("enter_y4", 32'(boss_y), 4);
      chk("sweep_r_phase", 32'(phase), 2);
      chk("sweep_r_x0", 32'(boss_x), 192);

      // Sweep with spawn_ready held low.
      step(4);                                        // edge 24
      chk("sweep_x193", 32'(boss_x), 193);
      chk("no_spawn_yet", 32'(spawn_valid), 0);
      step(8);                                        // edge 32: 3rd sweep tick fires
      chk("spawn_valid_rise", 32'(spawn_valid), 1);
      chk("spawn_x_premove", 32'(spawn_x), 194);
      chk("spawn_y", 32'(spawn_y), 4);
      chk("spawn_pat_aimed", 32'(spawn_pattern), 0);
      chk("sweep_x195", 32'(boss_x), 195);
      step(4);                                        // edge 36
      chk("turn_x196", 32'(boss_x), 196);
      chk("sweep_l_phase", 32'(phase), 3);
      step(8);                                        // edge 44: dropped fire event
      chk("sweep_l_x194", 32'(boss_x), 194);
      chk("drop_valid_held", 32'(spawn_valid), 1);
      chk("drop_sx_stable", 32'(spawn_x), 194);
      step(24);                                       // edge 68
      chk("turn_x188", 32'(boss_x), 188);
      chk("turn_back_phase", 32'(phase), 2);
      chk("sweep_y_const", 32'(boss_y), 4);
      chk("valid_still_high", 32'(spawn_valid), 1);

      spawn_ready = 1'b1;
      step(1);                                        // edge 69
      spawn_ready = 1'b0;
      chk("xfer_clear", 32'(spawn_valid), 0);

      // Held hit counts once.
      hit = 1'b1;
      step(1); chk("hit_first_edge", 32'(health), 7); // edge 70
      step(9); chk("hit_held", 32'(health), 7);       // edge 79
      hit = 1'b0;
      step(1);                                        // edge 80
      chk("spawn2_valid", 32'(spawn_valid), 1);
      chk("spawn2_x", 32'(spawn_x), 190);
      chk("spawn2_pat", 32'(spawn_pattern), 0);
      chk("spawn2_boss_x", 32'(boss_x), 191);

      repeat (5) begin
         hit = 1'b1; step(1);
         hit = 1'b0; step(1);
      end                                             // edge 90
      chk("health_2", 32'(health), 2);
      spawn_ready = 1'b1;
      step(1);                                        // edge 91
      spawn_ready = 1'b0;
      chk("xfer2_clear", 32'(spawn_valid), 0);
      step(1);                                        // edge 92
      chk("spawn3_valid", 32'(spawn_valid), 1);
      chk("spawn3_pat_spiral", 32'(spawn_pattern), 2);
      chk("spawn3_x", 32'(spawn_x), 193);

      // Death with a spawn pending.
      hit = 1'b1; step(1);                            // edge 93
      chk("health_1", 32'(health), 1);
      chk("alive_phase", 32'(phase), 2);
      hit = 1'b0; step(1);                            // edge 94
      hit = 1'b1; step(1);                            // edge 95
      hit = 1'b0;
      chk("dead_health", 32'(health), 0);
      chk("dead_phase", 32'(phase), 4);
      chk("dead_die", 32'(die), 1);
      chk("dead_active", 32'(active), 0);
      chk("dead_valid", 32'(spawn_valid), 0);
      chk("dead_x", 32'(boss_x), 194);
      start = 1'b1;
      step(1);                                        // edge 96
      start = 1'b0;
      chk("dead_ignores_start", 32'(phase), 4);
      step(3); chk("dead_tick_runs", 32'(frame_tick), 1); // edge 99
      step(1);                                        // edge 100
      chk("dead_x_frozen", 32'(boss_x), 194);
      chk("dead_y_frozen", 32'(boss_y), 4);
      hit = 1'b1; step(1); hit = 1'b0;
      chk("dead_health_sat", 32'(health), 0);

      // Restart, reach sweep with a pending spawn, then async reset between edges.
      reset = 1'b1; step(1);
      reset = 1'b0;
      start = 1'b1;
      step(1);                                        // edge 1
      start = 1'b0;
      chk("restart_phase", 32'(phase), 1);
      chk("restart_health", 32'(health), 8);
      step(15);                                       // edge 16
      chk("restart_sweep", 32'(phase), 2);
      step(12);                                       // edge 28
      chk("restart_spawn", 32'(spawn_valid), 1);
      chk("restart_sx", 32'(spawn_x), 194);
      step(2);
      #2 reset = 1'b1;
      #1 chk_reset_state("async");
      @(posedge clk_in); #1;
      reset = 1'b0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("post_reset_start", 32'(phase), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
